ctrl_linha_producao: RTL and testbench

//  Parametrised bottling-line controller: conveyor -> fill -> seal -> release, one bottle per cycle.

---
 rtl/ctrl_linha_producao.sv | 191 +++++++++++++++++++
 tb/tb_ctrl_linha_producao.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_linha_producao.sv
// ctrl_linha_producao: bottling-line controller (convey -> fill -> seal -> release).
// Drives conveyor motor (M), fill valve (EV) and sealer (VE) from the station
// sensors (PG/CH/RO). It counts produced bottles per batch and has a FAULT state
// for a stuck fill.
// Optional feature: define FILL_TIMEOUT_EN to enable the fill watchdog. Without it,
// FILL waits for CH indefinitely and FAULT cannot be reached.
// All outputs are registered and decoded from the next state, so they change on the
// same edge as the state register.
module ctrl_linha_producao #(
  parameter int SEAL_CYCLES  = 4,
  parameter int FILL_TIMEOUT = 1000,
  parameter int BATCH_SIZE   = 12,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             PG,
  input  logic             CH,
  input  logic             RO,
  input  logic             ack_fault,
  output logic             GP,
  output logic             M,
  output logic             EV,
  output logic             VE,
  output logic             no_cork,
  output logic             batch_done,
  output logic             fault,
  output logic [CNT_W-1:0] bottle_count,
  output logic [2:0]       state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONVEY  = 3'd1;
  localparam logic [2:0] S_FILL    = 3'd2;
  localparam logic [2:0] S_SEAL    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  // The seal timer only has to reach SEAL_CYCLES-1.
  localparam int ST_W = (SEAL_CYCLES > 1) ? $clog2(SEAL_CYCLES) : 1;
  localparam logic [ST_W-1:0]  SEAL_LAST  = ST_W'(SEAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BATCH_LAST = CNT_W'(BATCH_SIZE - 1);

  logic [2:0]       state_q, state_d;
  logic [ST_W-1:0]  seal_timer_q, seal_timer_d;
  logic [CNT_W-1:0] bottle_count_q, bottle_count_d;
  logic             gp_q, gp_d;
  logic             m_q, m_d;
  logic             ev_q, ev_d;
  logic             ve_q, ve_d;
  logic             no_cork_q, no_cork_d;
  logic             batch_done_q, batch_done_d;
  logic             fault_q, fault_d;

`ifdef FILL_TIMEOUT_EN
  localparam int FT_W = $clog2(FILL_TIMEOUT);
  localparam logic [FT_W-1:0] FILL_LAST = FT_W'(FILL_TIMEOUT - 1);

  logic [FT_W-1:0] fill_timer_q, fill_timer_d;

  // Fill watchdog: cleared outside FILL so each fill starts from zero, and it
  // saturates because FILL is left on the edge after FILL_LAST.
  always_comb begin
    fill_timer_d = fill_timer_q;
    if (state_q != S_FILL) begin
      fill_timer_d = '0;
    end else if (fill_timer_q != FILL_LAST) begin
      fill_timer_d = fill_timer_q + 1'b1;
    end
  end

  // Fill watchdog register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_timer_q <= '0;
    end else begin
      fill_timer_q <= fill_timer_d;
    end
  end
`endif

  // Next-state logic. In FILL, CH wins over the watchdog on the same cycle.
  // Once a bottle is in FILL it always finishes through RELEASE, even if start drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CONVEY;
      end
      S_CONVEY: begin
        if (!start)  state_d = S_IDLE;
        else if (PG) state_d = S_FILL;
      end
      S_FILL: begin
        if (CH) state_d = S_SEAL;
`ifdef FILL_TIMEOUT_EN
        else if (fill_timer_q == FILL_LAST) state_d = S_FAULT;
`endif
      end
      S_SEAL: begin
        if (RO && (seal_timer_q == SEAL_LAST)) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = start ? S_CONVEY : S_IDLE;
      end
      S_FAULT: begin
        if (ack_fault) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Seal timer: counts only the cycles with corks present. A cork shortage
  // freezes it, so the seal resumes exactly where it stopped.
  always_comb begin
    seal_timer_d = seal_timer_q;
    if (state_q != S_SEAL) begin
      seal_timer_d = '0;
    end else if (RO && (seal_timer_q != SEAL_LAST)) begin
      seal_timer_d = seal_timer_q + 1'b1;
    end
  end

  // Batch counter: bumps on entry to RELEASE, wraps to zero with batch_done on
  // the bottle that completes the batch.
  always_comb begin
    bottle_count_d = bottle_count_q;
    batch_done_d   = 1'b0;
    if (state_d == S_RELEASE) begin
      if (bottle_count_q == BATCH_LAST) begin
        bottle_count_d = '0;
        batch_done_d   = 1'b1;
      end else begin
        bottle_count_d = bottle_count_q + 1'b1;
      end
    end
  end

  // Actuator decode from the next state. EV and VE each own one state, so they
  // are exclusive with each other and with M by construction.
  always_comb begin
    m_d       = (state_d == S_CONVEY) || (state_d == S_RELEASE);
    ev_d      = (state_d == S_FILL);
    ve_d      = (state_d == S_SEAL) && RO;
    no_cork_d = (state_d == S_SEAL) && !RO;
    gp_d      = (state_d == S_RELEASE);
    fault_d   = (state_d == S_FAULT);
  end

  // State, timer, counter and output registers. An asynchronous reset drops
  // everything, so a partial bottle is never counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      seal_timer_q   <= '0;
      bottle_count_q <= '0;
      gp_q           <= 1'b0;
      m_q            <= 1'b0;
      ev_q           <= 1'b0;
      ve_q           <= 1'b0;
      no_cork_q      <= 1'b0;
      batch_done_q   <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      seal_timer_q   <= seal_timer_d;
      bottle_count_q <= bottle_count_d;
      gp_q           <= gp_d;
      m_q            <= m_d;
      ev_q           <= ev_d;
      ve_q           <= ve_d;
      no_cork_q      <= no_cork_d;
      batch_done_q   <= batch_done_d;
      fault_q        <= fault_d;
    end
  end

  assign state        = state_q;
  assign bottle_count = bottle_count_q;
  assign GP           = gp_q;
  assign M            = m_q;
  assign EV           = ev_q;
  assign VE           = ve_q;
  assign no_cork      = no_cork_q;
  assign batch_done   = batch_done_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_ctrl_linha_producao.sv
// Testbench for ctrl_linha_producao. Completed bottles are predicted into a
// scoreboard queue as CH is driven, and popped when GP is seen.
// Build with FILL_TIMEOUT_EN defined to exercise the fill watchdog.
module tb_ctrl_linha_producao;

  localparam int SEAL_CYCLES  = 4;
  localparam int FILL_TIMEOUT = 8;
  localparam int BATCH_SIZE   = 3;
  localparam int CNT_W        = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, PG, CH, RO, ack_fault;
  logic             GP, M, EV, VE, no_cork, batch_done, fault;
  logic [CNT_W-1:0] bottle_count;
  logic [2:0]       state;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             bd;
  } exp_t;

  exp_t exp_q[$];
  int   exp_count = 0;
  int   checks = 0;
  int   errors = 0;

  ctrl_linha_producao #(
    .SEAL_CYCLES (SEAL_CYCLES),
    .FILL_TIMEOUT(FILL_TIMEOUT),
    .BATCH_SIZE  (BATCH_SIZE),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .PG          (PG),
    .CH          (CH),
    .RO          (RO),
    .ack_fault   (ack_fault),
    .GP          (GP),
    .M           (M),
    .EV          (EV),
    .VE          (VE),
    .no_cork     (no_cork),
    .batch_done  (batch_done),
    .fault       (fault),
    .bottle_count(bottle_count),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predict the next completed bottle.
  task automatic push_exp();
    exp_t e;
    exp_count = (exp_count + 1) % BATCH_SIZE;
    e.cnt = CNT_W'(exp_count);
    e.bd  = (exp_count == 0);
    exp_q.push_back(e);
  endtask

  // Run the clock until GP appears (bounded), recording what was observed.
  task automatic wait_gp(output bit got, output int ve_n, output logic [CNT_W-1:0] cnt,
                         output logic bd, output bit excl_bad);
    got = 1'b0; ve_n = 0; cnt = '0; bd = 1'b0; excl_bad = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if ((EV && VE) || (M && (EV || VE))) excl_bad = 1'b1;
      if (GP) begin
        got = 1'b1; cnt = bottle_count; bd = batch_done;
      end else if (VE) begin
        ve_n++;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({GP, M, EV, VE, no_cork, batch_done, fault} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=0000000", {GP, M, EV, VE, no_cork, batch_done, fault});
    end
    checks++;
    if (state !== 3'd0 || bottle_count !== '0) begin
      errors++;
      $display("FAIL reset_state state=%0d count=%0d required state=0 count=0", state, bottle_count);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (state !== 3'd0 || M !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold state=%0d M=%b required state=0 M=0", state, M);
    end
  endtask

  task automatic test_single_bottle();
    bit got, bad; int ve_n; logic [CNT_W-1:0] cnt; logic bd; exp_t e;
    start = 1'b1;
    tick();
    checks++;
    if (state !== 3'd1 || M !== 1'b1 || EV !== 1'b0) begin
      errors++;
      $display("FAIL convey state=%0d M=%b EV=%b required 1/1/0", state, M, EV);
    end
    PG = 1'b1;
    tick();
    checks++;
    if (state !== 3'd2 || EV !== 1'b1 || M !== 1'b0) begin
      errors++;
      $display("FAIL fill_entry state=%0d EV=%b M=%b required 2/1/0", state, EV, M);
    end
    PG = 1'b0;
    tick();
    checks++;
    if (state !== 3'd2 || EV !== 1'b1) begin
      errors++;
      $display("FAIL fill_wait state=%0d EV=%b required 2/1", state, EV);
    end
    CH = 1'b1; RO = 1'b1; push_exp();
    tick();
    checks++;
    if (state !== 3'd3 || VE !== 1'b1 || M !== 1'b0 || EV !== 1'b0 || no_cork !== 1'b0) begin
      errors++;
      $display("FAIL seal_entry state=%0d VE=%b M=%b EV=%b no_cork=%b required 3/1/0/0/0",
               state, VE, M, EV, no_cork);
    end
    CH = 1'b0;
    wait_gp(got, ve_n, cnt, bd, bad);
    checks++;
    if (ve_n + 1 !== SEAL_CYCLES) begin
      errors++;
      $display("FAIL seal_len VE cycles=%0d required=%0d", ve_n + 1, SEAL_CYCLES);
    end
    checks++;
    if (!got || exp_q.size() == 0) begin
      errors++;
      $display("FAIL single_gp got=%0b queued=%0d required got=1", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (cnt !== e.cnt || bd !== e.bd) begin
        errors++;
        $display("FAIL single_gp count=%0d bd=%b required count=%0d bd=%b", cnt, bd, e.cnt, e.bd);
      end
    end
    checks++;
    if (bad || M !== 1'b1 || VE !== 1'b0) begin
      errors++;
      $display("FAIL release_act excl_bad=%0b M=%b VE=%b required 0/1/0", bad, M, VE);
    end
    tick();
    checks++;
    if (GP !== 1'b0 || state !== 3'd1 || M !== 1'b1) begin
      errors++;
      $display("FAIL release_one GP=%b state=%0d M=%b required 0/1/1", GP, state, M);
    end
  endtask

  task automatic test_no_cork();
    bit got, bad, stall_bad; int ve_n; logic [CNT_W-1:0] cnt; logic bd; exp_t e;
    PG = 1'b1;
    tick();
    PG = 1'b0; CH = 1'b1; RO = 1'b1; push_exp();
    tick();
    CH = 1'b0;
    tick();
    RO = 1'b0;
    stall_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (state !== 3'd3 || VE !== 1'b0 || no_cork !== 1'b1) stall_bad = 1'b1;
    end
    checks++;
    if (stall_bad) begin
      errors++;
      $display("FAIL no_cork_stall state=%0d VE=%b no_cork=%b required 3/0/1", state, VE, no_cork);
    end
    RO = 1'b1;
    wait_gp(got, ve_n, cnt, bd, bad);
    checks++;
    if (ve_n !== SEAL_CYCLES - 2) begin
      errors++;
      $display("FAIL seal_resume VE cycles=%0d required=%0d", ve_n, SEAL_CYCLES - 2);
    end
    checks++;
    if (!got || exp_q.size() == 0 || bad) begin
      errors++;
      $display("FAIL no_cork_gp got=%0b queued=%0d excl_bad=%0b required 1/>0/0", got, exp_q.size(), bad);
    end else begin
      e = exp_q.pop_front();
      if (cnt !== e.cnt || bd !== e.bd) begin
        errors++;
        $display("FAIL no_cork_gp count=%0d bd=%b required count=%0d bd=%b", cnt, bd, e.cnt, e.bd);
      end
    end
    tick();
  endtask

  task automatic test_batch();
    bit got, bad; int ve_n; logic [CNT_W-1:0] cnt; logic bd; exp_t e;
    for (int b = 0; b < 3; b++) begin
      PG = 1'b1;
      tick();
      PG = 1'b0; CH = 1'b1; RO = 1'b1; push_exp();
      tick();
      CH = 1'b0;
      wait_gp(got, ve_n, cnt, bd, bad);
      checks++;
      if (!got || exp_q.size() == 0) begin
        errors++;
        $display("FAIL batch_gp%0d got=%0b queued=%0d required got=1", b, got, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (cnt !== e.cnt || bd !== e.bd) begin
          errors++;
          $display("FAIL batch_gp%0d count=%0d bd=%b required count=%0d bd=%b", b, cnt, bd, e.cnt, e.bd);
        end
      end
      tick();
      checks++;
      if (batch_done !== 1'b0 || GP !== 1'b0) begin
        errors++;
        $display("FAIL batch_pulse%0d bd=%b GP=%b required 0/0", b, batch_done, GP);
      end
    end
  endtask

  task automatic test_stop();
    bit got, bad; int ve_n; logic [CNT_W-1:0] cnt; logic bd; exp_t e;
    PG = 1'b1;
    tick();
    PG = 1'b0; start = 1'b0;
    tick();
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL stop_in_fill state=%0d required=2", state);
    end
    CH = 1'b1; RO = 1'b1; push_exp();
    tick();
    CH = 1'b0;
    wait_gp(got, ve_n, cnt, bd, bad);
    checks++;
    if (!got || exp_q.size() == 0) begin
      errors++;
      $display("FAIL stop_gp got=%0b queued=%0d required got=1", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (cnt !== e.cnt || bd !== e.bd) begin
        errors++;
        $display("FAIL stop_gp count=%0d bd=%b required count=%0d bd=%b", cnt, bd, e.cnt, e.bd);
      end
    end
    tick();
    checks++;
    if (state !== 3'd0 || M !== 1'b0 || GP !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle state=%0d M=%b GP=%b required 0/0/0", state, M, GP);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || M !== 1'b0) begin
      errors++;
      $display("FAIL stop_convey state=%0d M=%b required 0/0", state, M);
    end
  endtask

  task automatic test_fill_timeout();
    bit got, bad, wait_bad; int ve_n; logic [CNT_W-1:0] cnt; logic bd; exp_t e;
    start = 1'b1;
    tick();
    PG = 1'b1;
    tick();
    PG = 1'b0;
    wait_bad = 1'b0;
`ifdef FILL_TIMEOUT_EN
    for (int i = 0; i < FILL_TIMEOUT - 1; i++) begin
      tick();
      if (state !== 3'd2 || fault !== 1'b0) wait_bad = 1'b1;
    end
    checks++;
    if (wait_bad) begin
      errors++;
      $display("FAIL fill_before_timeout state=%0d fault=%b required 2/0", state, fault);
    end
    tick();
    checks++;
    if (state !== 3'd5 || fault !== 1'b1 || EV !== 1'b0 || M !== 1'b0 || VE !== 1'b0) begin
      errors++;
      $display("FAIL timeout state=%0d fault=%b EV=%b M=%b VE=%b required 5/1/0/0/0",
               state, fault, EV, M, VE);
    end
    tick();
    tick();
    checks++;
    if (state !== 3'd5 || bottle_count !== CNT_W'(exp_count)) begin
      errors++;
      $display("FAIL fault_hold state=%0d count=%0d required state=5 count=%0d", state, bottle_count, exp_count);
    end
    ack_fault = 1'b1;
    tick();
    ack_fault = 1'b0;
    checks++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_ack state=%0d fault=%b required 0/0", state, fault);
    end
    tick();
    PG = 1'b1;
    tick();
    PG = 1'b0;
    for (int i = 0; i < FILL_TIMEOUT - 1; i++) tick();
`else
    for (int i = 0; i < 30; i++) begin
      tick();
      if (state !== 3'd2 || fault !== 1'b0 || EV !== 1'b1) wait_bad = 1'b1;
    end
    checks++;
    if (wait_bad) begin
      errors++;
      $display("FAIL fill_no_timeout state=%0d fault=%b EV=%b required 2/0/1", state, fault, EV);
    end
`endif
    CH = 1'b1; RO = 1'b1; push_exp();
    tick();
    CH = 1'b0;
    checks++;
    if (state !== 3'd3 || fault !== 1'b0) begin
      errors++;
      $display("FAIL ch_last_cycle state=%0d fault=%b required 3/0", state, fault);
    end
    wait_gp(got, ve_n, cnt, bd, bad);
    checks++;
    if (!got || exp_q.size() == 0) begin
      errors++;
      $display("FAIL timeout_gp got=%0b queued=%0d required got=1", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (cnt !== e.cnt || bd !== e.bd) begin
        errors++;
        $display("FAIL timeout_gp count=%0d bd=%b required count=%0d bd=%b", cnt, bd, e.cnt, e.bd);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_seal();
    bit got, bad; int ve_n; logic [CNT_W-1:0] cnt; logic bd; exp_t e;
    PG = 1'b1;
    tick();
    PG = 1'b0; CH = 1'b1; RO = 1'b0;
    tick();
    CH = 1'b0;
    tick();
    checks++;
    if (state !== 3'd3 || no_cork !== 1'b1 || bottle_count === '0) begin
      errors++;
      $display("FAIL pre_reset state=%0d no_cork=%b count=%0d required 3/1/nonzero", state, no_cork, bottle_count);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({GP, M, EV, VE, no_cork, batch_done, fault} !== 7'b0 || state !== 3'd0 || bottle_count !== '0) begin
      errors++;
      $display("FAIL async_reset outs=%b state=%0d count=%0d required 0/0/0",
               {GP, M, EV, VE, no_cork, batch_done, fault}, state, bottle_count);
    end
    exp_q.delete();
    exp_count = 0;
    RO = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    PG = 1'b1;
    tick();
    PG = 1'b0; CH = 1'b1; push_exp();
    tick();
    CH = 1'b0;
    wait_gp(got, ve_n, cnt, bd, bad);
    checks++;
    if (!got || exp_q.size() == 0) begin
      errors++;
      $display("FAIL post_reset_gp got=%0b queued=%0d required got=1", got, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (cnt !== e.cnt || bd !== e.bd) begin
        errors++;
        $display("FAIL post_reset_gp count=%0d bd=%b required count=%0d bd=%b", cnt, bd, e.cnt, e.bd);
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; PG = 1'b0; CH = 1'b0; RO = 1'b0; ack_fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_bottle();
    test_no_cork();
    test_batch();
    test_stop();
    test_fill_timeout();
    test_reset_mid_seal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
